// File: rtl/common_vl_pack.sv
// rtl/common_vl_pack.sv - vl_rec record type shared by receive_send and its consumers
package common_vl_pack;

  typedef struct packed {
    logic       vl_bit;
    logic [3:0] vl_arr;
  } vl_rec;

  localparam int VL_REC_W = $bits(vl_rec);

  // Flat storage element so the FIFO array does not depend on the struct layout
  typedef logic [VL_REC_W-1:0] vl_rec_q_t;

endpackage

// File: rtl/vl_rec_fifo_ctrl.sv
// rtl/vl_rec_fifo_ctrl.sv - pointer, occupancy and drop bookkeeping for vl_rec_buffer
module vl_rec_fifo_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              wr_en,
  output logic [PW-1:0]     wr_ptr,
  output logic [PW-1:0]     rd_ptr,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              pop, push, drop;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    pop   = !empty && out_ready;
    // A full buffer still accepts when the head leaves in the same cycle
    push  = in_valid && (!full || pop);
    drop  = in_valid && full && !pop;
    wr_en = push && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign wr_ptr   = wr_ptr_q;
  assign rd_ptr   = rd_ptr_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: rtl/vl_rec_buffer.sv
// rtl/vl_rec_buffer.sv - first-word-fall-through vl_rec FIFO with sticky drop statistics
module vl_rec_buffer
  import common_vl_pack::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  vl_rec             in_rec,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output vl_rec             out_rec,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  vl_rec_q_t     mem_q [DEPTH];
  logic          wr_en, full, empty;
  logic [PW-1:0] wr_ptr, rd_ptr;

  vl_rec_fifo_ctrl #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // Flush leaves storage alone; only reset guarantees out_rec reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= in_rec;
    end
  end

  assign out_rec   = vl_rec'(mem_q[rd_ptr]);
  assign out_valid = !empty;
  assign in_ready  = !full;

endmodule

// File: tb/tb_vl_rec_buffer.sv
// tb/tb_vl_rec_buffer.sv - directed vector bench for vl_rec_buffer
module tb_vl_rec_buffer;
  import common_vl_pack::*;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  vl_rec      in_rec;
  logic       in_ready, out_valid, overflow;
  vl_rec      out_rec;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  logic       rst2_n, in_valid2, out_ready2;
  vl_rec      in_rec2;
  logic       in_ready2, out_valid2, overflow2;
  vl_rec      out_rec2;
  logic [2:0] count2;
  logic [1:0] drop_cnt2;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vl_rec_buffer #(.DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_rec(in_rec),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  vl_rec_buffer #(.DEPTH(4), .DROP_W(2)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .flush(1'b0), .in_valid(in_valid2), .in_rec(in_rec2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2), .out_rec(out_rec2),
    .count(count2), .overflow(overflow2), .drop_cnt(drop_cnt2)
  );

  typedef struct {
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [4:0] in_rec;
    logic       out_ready;
    logic       e_valid;
    logic [2:0] e_count;
    logic       e_ready;
    logic       e_ovf;
    logic [7:0] e_drop;
    logic       chk_rec;
    logic [4:0] e_rec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [4:0] rec,
                              input logic ordy, input logic ev, input logic [2:0] ec,
                              input logic er, input logic eo, input logic [7:0] ed,
                              input logic cr, input logic [4:0] erec);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_rec = rec; v.out_ready = ordy;
    v.e_valid = ev; v.e_count = ec; v.e_ready = er; v.e_ovf = eo; v.e_drop = ed;
    v.chk_rec = cr; v.e_rec = erec;
    return v;
  endfunction

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_rec = '0; out_ready = 0;
    rst2_n = 0; in_valid2 = 0; in_rec2 = '0; out_ready2 = 0;

    //           rst f  iv rec     ordy  v  cnt rdy ovf drop  chk rec
    vecs.push_back(mk(0, 0, 0, 5'd0,  0,   0, 0,  1,  0,  0,   1, 5'd0));
    vecs.push_back(mk(0, 0, 0, 5'd0,  0,   0, 0,  1,  0,  0,   1, 5'd0));
    vecs.push_back(mk(1, 0, 0, 5'd0,  0,   0, 0,  1,  0,  0,   1, 5'd0));
    vecs.push_back(mk(1, 0, 1, 5'b11010, 0, 1, 1, 1,  0,  0,   1, 5'b11010));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   0, 0,  1,  0,  0,   0, 5'd0));
    // fill with 16..21, last two dropped
    vecs.push_back(mk(1, 0, 1, 5'd16, 0,   1, 1,  1,  0,  0,   1, 5'd16));
    vecs.push_back(mk(1, 0, 1, 5'd17, 0,   1, 2,  1,  0,  0,   1, 5'd16));
    vecs.push_back(mk(1, 0, 1, 5'd18, 0,   1, 3,  1,  0,  0,   1, 5'd16));
    vecs.push_back(mk(1, 0, 1, 5'd19, 0,   1, 4,  0,  0,  0,   1, 5'd16));
    vecs.push_back(mk(1, 0, 1, 5'd20, 0,   1, 4,  0,  1,  1,   1, 5'd16));
    vecs.push_back(mk(1, 0, 1, 5'd21, 0,   1, 4,  0,  1,  2,   1, 5'd16));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   1, 3,  1,  1,  2,   1, 5'd17));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   1, 2,  1,  1,  2,   1, 5'd18));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   1, 1,  1,  1,  2,   1, 5'd19));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   0, 0,  1,  1,  2,   0, 5'd0));
    // full with 20..23, then push 24 while popping
    vecs.push_back(mk(1, 0, 1, 5'd20, 0,   1, 1,  1,  1,  2,   1, 5'd20));
    vecs.push_back(mk(1, 0, 1, 5'd21, 0,   1, 2,  1,  1,  2,   1, 5'd20));
    vecs.push_back(mk(1, 0, 1, 5'd22, 0,   1, 3,  1,  1,  2,   1, 5'd20));
    vecs.push_back(mk(1, 0, 1, 5'd23, 0,   1, 4,  0,  1,  2,   1, 5'd20));
    vecs.push_back(mk(1, 0, 1, 5'd24, 1,   1, 4,  0,  1,  2,   1, 5'd21));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   1, 3,  1,  1,  2,   1, 5'd22));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   1, 2,  1,  1,  2,   1, 5'd23));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   1, 1,  1,  1,  2,   1, 5'd24));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   0, 0,  1,  1,  2,   0, 5'd0));
    // three stored, then flush with a colliding input
    vecs.push_back(mk(1, 0, 1, 5'd25, 0,   1, 1,  1,  1,  2,   1, 5'd25));
    vecs.push_back(mk(1, 0, 1, 5'd26, 0,   1, 2,  1,  1,  2,   1, 5'd25));
    vecs.push_back(mk(1, 0, 1, 5'd27, 0,   1, 3,  1,  1,  2,   1, 5'd25));
    vecs.push_back(mk(1, 1, 1, 5'd30, 0,   0, 0,  1,  0,  0,   0, 5'd0));
    vecs.push_back(mk(1, 0, 0, 5'd0,  0,   0, 0,  1,  0,  0,   0, 5'd0));
    vecs.push_back(mk(1, 0, 1, 5'd9,  0,   1, 1,  1,  0,  0,   1, 5'd9));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   0, 0,  1,  0,  0,   0, 5'd0));
    vecs.push_back(mk(1, 0, 0, 5'd0,  1,   0, 0,  1,  0,  0,   0, 5'd0));
    // reset mid-stream wipes contents and storage
    vecs.push_back(mk(1, 0, 1, 5'd7,  0,   1, 1,  1,  0,  0,   1, 5'd7));
    vecs.push_back(mk(1, 0, 1, 5'd8,  0,   1, 2,  1,  0,  0,   1, 5'd7));
    vecs.push_back(mk(0, 0, 1, 5'd11, 1,   0, 0,  1,  0,  0,   1, 5'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; flush = vecs[i].flush; in_valid = vecs[i].in_valid;
      in_rec = vl_rec'(vecs[i].in_rec); out_ready = vecs[i].out_ready;
      @(posedge clk);
      #1;
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
      check("count",     i, 32'(count),     32'(vecs[i].e_count));
      check("in_ready",  i, 32'(in_ready),  32'(vecs[i].e_ready));
      check("overflow",  i, 32'(overflow),  32'(vecs[i].e_ovf));
      check("drop_cnt",  i, 32'(drop_cnt),  32'(vecs[i].e_drop));
      if (vecs[i].chk_rec) check("out_rec", i, 32'(out_rec), 32'(vecs[i].e_rec));
    end

    // drop counter saturation on the DROP_W=2 instance
    @(negedge clk); rst2_n = 0;
    @(negedge clk); rst2_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid2 = 1; in_rec2 = vl_rec'(5'(k + 1));
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); in_valid2 = 1; in_rec2 = vl_rec'(5'd31);
      @(posedge clk); #1;
      check("sat_drop", k, 32'(drop_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
      check("sat_ovf",  k, 32'(overflow2), 32'd1);
    end
    @(negedge clk); in_valid2 = 0; out_ready2 = 1;
    for (int k = 0; k < 4; k++) begin
      check("sat_head", k, 32'(out_rec2), 32'(k + 1));
      @(posedge clk); #1;
    end
    check("sat_count", 0, 32'(count2), 32'd0);
    check("sat_hold",  0, 32'(drop_cnt2), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/vl_rec_buffer.md
Name: vl_rec_buffer

Overview:
- Downstream consumer stage for the receive_send output stream.
- Captures one vl_rec per clock when the producer flags it valid and holds records in a small FIFO.
- Presents records to a consumer over a valid/ready handshake, first-word-fall-through.
- The producer has no backpressure, so the block drops records when full and keeps sticky overflow/drop statistics for the bench and monitors.

Parameters:
- DEPTH, 4, number of vl_rec entries; power of two, >= 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous clear of contents and statistics.
- in_valid  input  1  in_rec carries a new record this cycle.
- in_rec  input  vl_rec (5)  record from receive_send (vl_bit, vl_arr[3:0]).
- in_ready  output  1  informational: buffer can accept; producer ignores it.
- out_valid  output  1  out_rec holds the oldest stored record.
- out_ready  input  1  consumer takes out_rec this cycle.
- out_rec  output  vl_rec (5)  oldest record.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one record dropped.
- drop_cnt  output  DROP_W  number of dropped records, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, in_ready=1, count=0, overflow=0, drop_cnt=0, out_rec=0.
  - Pointers are 0 and all storage entries are 0.
- Clock enable and precedence: reset > flush > normal operation.
- Flush:
  - Same effect as reset, except storage contents need not be zeroed.
  - out_rec reads 0 only after reset; after flush out_rec is don't-care while out_valid=0.
  - in_valid in the flush cycle is discarded and is not counted as a drop.
- Definitions: full = (count==DEPTH); empty = (count==0); pop = out_valid & out_ready; push = in_valid & (!full | pop).
- Push: write in_rec at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Pointer width is $clog2(DEPTH); wrap from DEPTH-1 to 0 is natural.
- Latency:
  - A record pushed into an empty buffer gives out_valid=1 the next cycle.
  - There is no same-cycle bypass, so empty plus in_valid never pops that cycle.
- Output signals:
  - out_valid = !empty (registered count).
  - out_rec = storage[rd_ptr]; stable while out_valid=1 and out_ready=0.
  - in_ready = !full.
- Full plus in_valid plus pop in the same cycle: the record is accepted, count stays DEPTH, no drop.
- Drop: in_valid & full & !pop sets overflow=1 and increments drop_cnt.
  - drop_cnt saturates at 2^DROP_W-1.
  - The dropped record does not disturb storage or pointers.
- overflow and drop_cnt clear only on reset or flush.
- Reset or flush asserted mid-stream: all pending records are lost; the next cycle behaves as empty.
- out_ready with out_valid=0: no effect.

Decomposition:
- common_vl_pack keeps the vl_rec typedef.
- Add to common_vl_pack:
  - localparam VL_REC_W = 5 (packed width of vl_rec).
  - typedef vl_rec_q_t for the storage array element.
- Sub-module vl_rec_fifo_ctrl:
  - Takes clk, rst_n, flush, in_valid, out_ready.
  - Produces wr_en, wr_ptr, rd_ptr, count, full, empty, overflow, drop_cnt.
- Top vl_rec_buffer owns the storage array and the output mux.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> out_valid=0, count=0, in_ready=1, overflow=0, drop_cnt=0, out_rec=5'b0.
- Single record: in_valid=1 for one cycle with in_rec={vl_bit=1, vl_arr=4'b1010}, out_ready=0.
  - Next cycle: out_valid=1, count=1, out_rec={1,1010}.
  - Assert out_ready: one cycle later out_valid=0, count=0.
- Fill and drop (DEPTH=4): push records 0..5 on consecutive cycles with out_ready=0.
  - Required: count=4, in_ready=0, overflow=1, drop_cnt=2.
  - Draining yields records 0,1,2,3 in order.
- Full with simultaneous push/pop: buffer full with 0..3, out_ready=1 and in_valid=1 with record 4.
  - Required: pop returns record 0, count stays 4, drop_cnt unchanged.
  - Wrap-around continues correctly: drain yields 1,2,3,4.
- Flush priority: 3 records stored, drop_cnt=1, then flush=1 with in_valid=1.
  - Next cycle: count=0, out_valid=0, overflow=0, drop_cnt=0.
  - The input in the flush cycle does not appear at the output.
- Drop saturation (DROP_W=2): fill the buffer, then hold in_valid=1 and out_ready=0 for 6 cycles -> drop_cnt=3 and holds, overflow=1.
